sobel_frame_ctrl: RTL
=====================

Name: sobel_frame_ctrl

Overview:
- Frame sequencer for the Sobel datapath. It sits between the APB register file (width, height, start) and the pixel stream.
- After start, it accepts exactly width*height pixels and tracks row/column. It flags when the 3x3 window is complete, counts datapath outputs against the expected (W-2)*(H-2), and then issues done.
- It replaces ad-hoc total-pixel bookkeeping with a checked, abortable state machine.

Parameters:
- COORD_W, 12, width of cfg_width/cfg_height and row/col counters (max 4095).
- CNT_W, 24, width of output counter and expected-count register.
- TIMEOUT, 1024, idle cycles without dp_valid in DRAIN before forced completion.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_width  in  COORD_W  image width in pixels; sampled on accepted start.
- cfg_height  in  COORD_W  image height in pixels; sampled on accepted start.
- start  in  1  one-cycle start request; honoured only in IDLE.
- abort  in  1  abandon current frame.
- valid_in  in  1  pixel presented on the stream this cycle.
- in_ready  out  1  controller accepts pixels; a beat is accepted when valid_in && in_ready.
- lb_wr_en  out  1  line-buffer write enable; equals the accept condition (combinational).
- col  out  COORD_W  column of the pixel presented this cycle (registered counter).
- row  out  COORD_W  row of the pixel presented this cycle (registered counter).
- win_valid  out  1  accept && row>=2 && col>=2 (combinational); the window centred at (row-1, col-1) is complete.
- dp_valid  in  1  datapath produced one output pixel.
- out_count  out  CNT_W  dp_valid beats counted since the last accepted start.
- busy  out  1  high in STREAM and DRAIN.
- done  out  1  one-cycle pulse on frame completion.
- cfg_err  out  1  one-cycle pulse when start is rejected for bad config.
- timeout_flag  out  1  sticky; set when DRAIN times out; cleared on next accepted start.
- ovf_flag  out  1  sticky; set when dp_valid arrives in IDLE/DONE or beyond the expected count; cleared on next accepted start.

Behaviour:
- Reset: state=IDLE. col, row, out_count, in_ready, busy, done, cfg_err, timeout_flag and ovf_flag are all 0. Reset mid-frame discards the frame with no done.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE, in_ready=0:
  - start with cfg_width>=3 and cfg_height>=3: latch W, H; expected = (W-2)*(H-2), truncated to CNT_W. Clear col, row, out_count and both sticky flags. Next state STREAM.
  - start with W<3 or H<3: cfg_err=1 for the following cycle; stay IDLE; no other state changes.
- STREAM, in_ready=1:
  - On accept: if col==W-1, then col<=0 and row<=row+1; else col<=col+1.
  - On accept of the pixel at row==H-1 and col==W-1, go to DRAIN next cycle.
  - valid_in bubbles stall the counters and do not change state.
- DRAIN, in_ready=0:
  - Wait for out_count==expected, then go to DONE.
  - An idle counter resets on each dp_valid. When it reaches TIMEOUT, set timeout_flag and go to DONE.
- DONE: done=1 for exactly this cycle, busy=0; next state IDLE. out_count holds until the next accepted start.
- dp_valid counting:
  - Counted in STREAM and DRAIN while out_count<expected.
  - If out_count==expected already, or the state is IDLE/DONE: out_count is unchanged and ovf_flag is set.
  - If out_count reaches expected during STREAM, the controller still drains the remaining input, then goes DRAIN->DONE one cycle after entering DRAIN.
- start while busy is ignored, with no error pulse.
- abort in STREAM or DRAIN: next state IDLE; in_ready drops next cycle; no done; counters hold for debug.
- Simultaneous abort and start in IDLE: start wins. Simultaneous reset and anything: reset wins.

Test Plan:
- W=5, H=4; 20 contiguous pixels; datapath model echoes each win_valid as dp_valid 3 cycles later -> win_valid high 6 times, at (row,col) = (2,2),(2,3),(2,4),(3,2),(3,3),(3,4). in_ready drops after the 20th beat; done pulses once, 1 cycle after out_count reaches 6; timeout_flag=0.
- Same frame with valid_in toggled 1-0-1-0 -> identical row/col sequence across accepted beats; done pulses once, 1 cycle after out_count reaches 6.
- start with W=2, H=10 -> cfg_err pulse 1 cycle; in_ready stays 0; busy stays 0.
- W=8, H=8; abort after 30 pixels -> in_ready=0 next cycle, state IDLE, no done. A new start with W=4, H=4 completes with done after out_count reaches 4.
- W=4, H=4 with datapath model dropping its last output; TIMEOUT=16 -> 16 idle cycles in DRAIN, then timeout_flag=1, done pulse, out_count=3.
- Extra dp_valid after done -> ovf_flag=1, out_count unchanged. Reset asserted mid-STREAM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sobel_frame_ctrl
// Frame sequencer for the Sobel datapath: pixel accept, row/col tracking,
//          output counting against (W-2)*(H-2), drain timeout and abort.
// Rev    : 1.0
// ============================================================================
module sobel_frame_ctrl #(
  parameter int COORD_W = 12,
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic               start,
  input  logic               abort,
  input  logic               valid_in,
  output logic               in_ready,
  output logic               lb_wr_en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               win_valid,
  input  logic               dp_valid,
  output logic [CNT_W-1:0]   out_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               timeout_flag,
  output logic               ovf_flag
);

  localparam int PW     = 2 * COORD_W;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [COORD_W-1:0] c_one   = COORD_W'(1);
  localparam logic [COORD_W-1:0] c_two   = COORD_W'(2);
  localparam logic [COORD_W-1:0] c_three = COORD_W'(3);
  localparam logic [IDLE_W-1:0]  c_idle_last = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_w;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [CNT_W-1:0]   r_expected;
  logic [CNT_W-1:0]   r_out_count;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;
  logic               r_timeout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last_col;
  logic               w_last_pix;
  logic               w_cfg_ok;
  logic               w_dp_countable;
  logic [PW-1:0]      w_wm2;
  logic [PW-1:0]      w_hm2;
  logic [PW-1:0]      w_prod;

  assign w_accept       = valid_in && r_in_ready;
  assign w_last_col     = (r_col == r_w - c_one);
  assign w_last_pix     = w_last_col && (r_row == r_h - c_one);
  assign w_cfg_ok       = (cfg_width >= c_three) && (cfg_height >= c_three);
  assign w_wm2          = PW'(cfg_width) - PW'(2);
  assign w_hm2          = PW'(cfg_height) - PW'(2);
  assign w_prod         = w_wm2 * w_hm2;
  assign w_dp_countable = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                          (r_out_count < r_expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_h         <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_expected  <= '0;
      r_out_count <= '0;
      r_idle      <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_timeout   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      // Output beats outside an active frame or past the expected total are overflow.
      if (dp_valid) begin
        if (w_dp_countable) r_out_count <= r_out_count + CNT_W'(1);
        else                r_ovf       <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_w         <= cfg_width;
              r_h         <= cfg_height;
              r_expected  <= CNT_W'(w_prod);
              r_col       <= '0;
              r_row       <= '0;
              r_out_count <= '0;
              r_ovf       <= 1'b0;
              r_timeout   <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_STREAM;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          r_idle <= '0;
          if (w_accept) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + c_one;
            end else begin
              r_col <= r_col + c_one;
            end
          end
          if (abort) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_accept && w_last_pix) begin
            r_in_ready <= 1'b0;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_out_count == r_expected) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (dp_valid) begin
            r_idle <= '0;
          end else if (r_idle == c_idle_last) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign lb_wr_en     = w_accept;
  assign col          = r_col;
  assign row          = r_row;
  assign win_valid    = w_accept && (r_row >= c_two) && (r_col >= c_two);
  assign out_count    = r_out_count;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cfg_err      = r_cfg_err;
  assign timeout_flag = r_timeout;
  assign ovf_flag     = r_ovf;

endmodule
`default_nettype wire
